instr_issue: RTL and testbench
==============================

# instr_issue

Reads a packed 64-bit instruction image (eight 8-bit instructions, as assembled by the button-driven input loader) and issues it one instruction per slot into the 5-stage pipeline over a valid/ready handshake. It detects RAW hazards against the two previously issued slots and inserts noop bubbles (8'h00) until each hazard clears. It is the consumer/reader counterpart of the instruction loader and the hazard checker: the hazard checker reports hazards, and this block resolves them by stalling.

## Interface
- No parameters. Image size is fixed at 8 instructions × 8 bits.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- load  input  1  start request; samples instr_bits. Honoured only in IDLE.
- instr_bits  input  64  image; [63:56] is instruction 0, [7:0] is instruction 7.
- issue_ready  input  1  pipeline accepts the current slot.
- instr_out  output  8  instruction or bubble for the current slot.
- instr_valid  output  1  instr_out is valid.
- bubble  output  1  current slot is an inserted bubble, not an image instruction.
- busy  output  1  state is RUN.
- done  output  1  one-cycle pulse after the last instruction is accepted.
- bubble_cnt  output  4  number of bubbles inserted for the current/last image.

## Operation
- Instruction format: opc = [7:6], A = [5:3], B = [2:0].
  - lw = 11, sw = 10, add = 01, noop = 00.
- Destination registers:
  - lw and add write A.
  - sw and noop write nothing.
- Source registers:
  - add reads A and B.
  - lw reads B.
  - sw reads A and B.
  - noop reads nothing.
- The pipeline has no forwarding. A consumer must issue at least 3 slots after its producer.
- History: two entries, h1 (previous accepted slot) and h2 (the slot before that). Each entry holds {dvalid, dreg}.
  - Bubbles and image noops enter the history with dvalid = 0.
- Hazard: the current image instruction reads register r, and h1 or h2 has dvalid = 1 with dreg == r. While a hazard is present, the slot presents a bubble: instr_out = 8'h00, bubble = 1.
- On an accepted slot (instr_valid & issue_ready):
  - h2 ← h1.
  - h1 ← destination of the slot.
  - If the slot was a bubble: bubble_cnt increments and the index holds.
  - Otherwise the index increments.
- Hazard evaluation is repeated every slot, so the bubble count per instruction is 0, 1 or 2.
- Image noops are issued as-is, count as real slots, and are not counted in bubble_cnt.
- States:
  - IDLE: instr_valid = 0, busy = 0. On load: capture instr_bits, index ← 0, h1 = h2 = invalid, bubble_cnt ← 0, go to RUN.
  - RUN: instr_valid = 1, busy = 1. When index 7 is accepted as a non-bubble: go to IDLE and assert done for the next cycle.
- load is ignored in RUN. The captured image and the counter are unaffected.
- bubble_cnt holds its value in IDLE until the next load. It cannot overflow: the maximum is 14.
- Reset (async, any time): state IDLE, instr_out = 0, instr_valid = 0, bubble = 0, busy = 0, done = 0, bubble_cnt = 0, index = 0, history invalid, image register = 0.

## Timing
- load sampled high at edge k: instr_valid = 1 after edge k; the first slot is visible in cycle k+1.
- With issue_ready held high, one slot is accepted per cycle. N instructions plus B bubbles take N + B cycles.
- instr_out, instr_valid and bubble are functions of registered state only. There is no combinational path from issue_ready or load to any output.
- While instr_valid = 1 and issue_ready = 0, instr_out and bubble must hold stable. History, index and bubble_cnt do not change.
- done is high for exactly the cycle after the final acceptance. busy drops in that same cycle.
- load asserted in the same cycle done is high is honoured, because the state is IDLE.

## Test plan
- No hazards: image 48 50 58 60 68 70 78 00 with issue_ready = 1. Required: 8 consecutive slots in that order, bubble never set, bubble_cnt = 0, done pulses in cycle 9 after load.
- Back-to-back load-use: image C8 51 00 00 00 00 00 00. Required slot sequence: C8, 00(b), 00(b), 51, 00 ×6. Here (b) marks a slot with bubble = 1. Final bubble_cnt = 2.
- Distance-2 hazard: image C8 00 51 00 00 00 00 00. Required: C8, 00, 00(b), 51, … with bubble_cnt = 1. The image noop has bubble = 0.
- Backpressure during a bubble: as the back-to-back case, with issue_ready low for 3 cycles on the first bubble. Required: instr_out = 00 and bubble = 1 held, bubble_cnt stays 0, then the same sequence resumes.
- Reset mid-run: assert rst_n = 0 after 3 accepted slots. Required: all outputs 0 immediately, without waiting for a clock. A subsequent load restarts from instruction 0 with clear history.
- load during RUN: pulse load with a different image at slot 4. Required: it is ignored, and the original image completes unchanged.

Source files
------------

// File: rtl/instr_issue_if.sv
// Handshake bundle between the image issuer and whoever loads it and consumes its slots.
// The master side loads the image and accepts slots; the slave side is the issuer.
interface instr_issue_if;
  logic        load;
  logic [63:0] instr_bits;
  logic        issue_ready;
  logic [7:0]  instr_out;
  logic        instr_valid;
  logic        bubble;
  logic        busy;
  logic        done;
  logic [3:0]  bubble_cnt;

  modport master (
    output load, instr_bits, issue_ready,
    input  instr_out, instr_valid, bubble, busy, done, bubble_cnt
  );

  modport slave (
    input  load, instr_bits, issue_ready,
    output instr_out, instr_valid, bubble, busy, done, bubble_cnt
  );
endinterface

// File: rtl/instr_issue.sv
// Issues an 8-instruction image one slot at a time into a non-forwarding 5-stage pipeline,
// inserting noop bubbles while the current instruction reads a register written by either of the last two slots.
module instr_issue (
  input  logic           clk,
  input  logic           rst_n,
  instr_issue_if.slave   bus
);

  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [1:0] OPC_LW   = 2'b11;
  localparam logic [1:0] OPC_SW   = 2'b10;
  localparam logic [1:0] OPC_ADD  = 2'b01;
  localparam logic [1:0] OPC_NOOP = 2'b00;

  state_e      state_q;
  logic [63:0] image_q;
  logic [2:0]  idx_q;
  logic        h1Valid_q, h2Valid_q;
  logic [2:0]  h1Reg_q, h2Reg_q;
  logic [3:0]  bubbleCnt_q;
  logic        done_q;

  logic [7:0]  curInstr;
  logic [1:0]  curOpc;
  logic [2:0]  curA, curB;
  logic        readsA, readsB, writesA;
  logic        hitA, hitB, hazard;
  logic        running, accept;
  logic        h1Valid_d;

  // Instruction 0 lives in the top byte, so the slot index counts down from the MSB end.
  always_comb begin
    curInstr  = image_q[{~idx_q, 3'b000} +: 8];
    curOpc    = curInstr[7:6];
    curA      = curInstr[5:3];
    curB      = curInstr[2:0];
    readsA    = (curOpc == OPC_ADD) || (curOpc == OPC_SW);
    readsB    = (curOpc != OPC_NOOP);
    writesA   = (curOpc == OPC_LW) || (curOpc == OPC_ADD);
    hitA      = (h1Valid_q && (h1Reg_q == curA)) || (h2Valid_q && (h2Reg_q == curA));
    hitB      = (h1Valid_q && (h1Reg_q == curB)) || (h2Valid_q && (h2Reg_q == curB));
    running   = (state_q == RUN);
    hazard    = running && ((readsA && hitA) || (readsB && hitB));
    accept    = running && bus.issue_ready;
    h1Valid_d = writesA && !hazard;
  end

  assign bus.instr_out   = (running && !hazard) ? curInstr : 8'h00;
  assign bus.instr_valid = running;
  assign bus.bubble      = hazard;
  assign bus.busy        = running;
  assign bus.done        = done_q;
  assign bus.bubble_cnt  = bubbleCnt_q;

  // A bubble keeps the index so the same instruction is re-evaluated against the shifted history next slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      image_q     <= 64'h0;
      idx_q       <= 3'd0;
      h1Valid_q   <= 1'b0;
      h2Valid_q   <= 1'b0;
      h1Reg_q     <= 3'd0;
      h2Reg_q     <= 3'd0;
      bubbleCnt_q <= 4'd0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.load) begin
            state_q     <= RUN;
            image_q     <= bus.instr_bits;
            idx_q       <= 3'd0;
            h1Valid_q   <= 1'b0;
            h2Valid_q   <= 1'b0;
            h1Reg_q     <= 3'd0;
            h2Reg_q     <= 3'd0;
            bubbleCnt_q <= 4'd0;
          end
        end
        RUN: begin
          if (accept) begin
            h2Valid_q <= h1Valid_q;
            h2Reg_q   <= h1Reg_q;
            h1Valid_q <= h1Valid_d;
            h1Reg_q   <= curA;
            if (hazard) begin
              bubbleCnt_q <= bubbleCnt_q + 4'd1;
            end else if (idx_q == 3'd7) begin
              state_q <= IDLE;
              idx_q   <= 3'd0;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_issue.sv
// Directed bench for instr_issue: fixed images with hand-derived slot sequences, bubbles and done timing.
module tb_instr_issue;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  instr_issue_if bus ();

  instr_issue dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [63:0] IMG_NOHAZ = 64'h4850_5860_6870_7800;
  localparam logic [63:0] IMG_B2B   = 64'hC851_0000_0000_0000;
  localparam logic [63:0] IMG_DIST2 = 64'hC800_5100_0000_0000;
  localparam logic [63:0] IMG_TAIL  = 64'h5100_0000_0000_00C8;
  localparam logic [63:0] IMG_HEAD  = 64'h5100_0000_0000_0000;

  localparam logic [7:0] NOHAZ_OUT [8]  = '{8'h48, 8'h50, 8'h58, 8'h60, 8'h68, 8'h70, 8'h78, 8'h00};
  localparam logic [7:0] B2B_OUT   [10] = '{8'hC8, 8'h00, 8'h00, 8'h51, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  localparam logic       B2B_BUB   [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [7:0] DIST_OUT  [9]  = '{8'hC8, 8'h00, 8'h00, 8'h51, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  localparam logic       DIST_BUB  [9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  // Load pulse spanning one rising edge; returns at the negedge where the first slot is visible.
  task automatic applyStimulus(input logic [63:0] img);
    @(negedge clk);
    bus.instr_bits = img;
    bus.load       = 1'b1;
    @(negedge clk);
    bus.load       = 1'b0;
  endtask

  task automatic test_reset();
    rst_n           = 1'b0;
    bus.load        = 1'b0;
    bus.instr_bits  = 64'h0;
    bus.issue_ready = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.instr_out, bus.instr_valid, bus.bubble, bus.busy, bus.done, bus.bubble_cnt} !== 16'h0) begin
      bad++;
      $display("[TB] FAIL reset_outputs got out=%h v=%b b=%b busy=%b done=%b cnt=%0d expected all zero",
               bus.instr_out, bus.instr_valid, bus.bubble, bus.busy, bus.done, bus.bubble_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus.instr_valid !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL idle_after_reset got v=%b busy=%b expected 0 0", bus.instr_valid, bus.busy);
    end
  endtask

  task automatic test_no_hazard();
    applyStimulus(IMG_NOHAZ);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (bus.instr_out !== NOHAZ_OUT[i] || bus.bubble !== 1'b0 || bus.instr_valid !== 1'b1) begin
        bad++;
        $display("[TB] FAIL nohaz_slot%0d got out=%h b=%b v=%b expected out=%h b=0 v=1",
                 i, bus.instr_out, bus.bubble, bus.instr_valid, NOHAZ_OUT[i]);
      end
      @(negedge clk);
    end
    total++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.bubble_cnt !== 4'd0) begin
      bad++;
      $display("[TB] FAIL nohaz_done got done=%b busy=%b cnt=%0d expected 1 0 0", bus.done, bus.busy, bus.bubble_cnt);
    end
    @(negedge clk);
    total++;
    if (bus.done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL nohaz_done_pulse got done=%b expected 0", bus.done);
    end
  endtask

  task automatic test_back_to_back();
    applyStimulus(IMG_B2B);
    for (int i = 0; i < 10; i++) begin
      total++;
      if (bus.instr_out !== B2B_OUT[i] || bus.bubble !== B2B_BUB[i]) begin
        bad++;
        $display("[TB] FAIL b2b_slot%0d got out=%h b=%b expected out=%h b=%b",
                 i, bus.instr_out, bus.bubble, B2B_OUT[i], B2B_BUB[i]);
      end
      @(negedge clk);
    end
    total++;
    if (bus.done !== 1'b1 || bus.bubble_cnt !== 4'd2) begin
      bad++;
      $display("[TB] FAIL b2b_done got done=%b cnt=%0d expected 1 2", bus.done, bus.bubble_cnt);
    end
    @(negedge clk);
    total++;
    if (bus.bubble_cnt !== 4'd2 || bus.busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL b2b_cnt_hold got cnt=%0d busy=%b expected 2 0", bus.bubble_cnt, bus.busy);
    end
  endtask

  task automatic test_distance2();
    applyStimulus(IMG_DIST2);
    for (int i = 0; i < 9; i++) begin
      total++;
      if (bus.instr_out !== DIST_OUT[i] || bus.bubble !== DIST_BUB[i]) begin
        bad++;
        $display("[TB] FAIL dist2_slot%0d got out=%h b=%b expected out=%h b=%b",
                 i, bus.instr_out, bus.bubble, DIST_OUT[i], DIST_BUB[i]);
      end
      @(negedge clk);
    end
    total++;
    if (bus.done !== 1'b1 || bus.bubble_cnt !== 4'd1) begin
      bad++;
      $display("[TB] FAIL dist2_done got done=%b cnt=%0d expected 1 1", bus.done, bus.bubble_cnt);
    end
  endtask

  task automatic test_backpressure();
    applyStimulus(IMG_B2B);
    total++;
    if (bus.instr_out !== 8'hC8) begin
      bad++;
      $display("[TB] FAIL bp_slot0 got out=%h expected c8", bus.instr_out);
    end
    @(negedge clk);
    bus.issue_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      total++;
      if (bus.instr_out !== 8'h00 || bus.bubble !== 1'b1 || bus.instr_valid !== 1'b1 || bus.bubble_cnt !== 4'd0) begin
        bad++;
        $display("[TB] FAIL bp_hold%0d got out=%h b=%b v=%b cnt=%0d expected 00 1 1 0",
                 j, bus.instr_out, bus.bubble, bus.instr_valid, bus.bubble_cnt);
      end
      @(negedge clk);
    end
    bus.issue_ready = 1'b1;
    for (int i = 1; i < 10; i++) begin
      total++;
      if (bus.instr_out !== B2B_OUT[i] || bus.bubble !== B2B_BUB[i]) begin
        bad++;
        $display("[TB] FAIL bp_slot%0d got out=%h b=%b expected out=%h b=%b",
                 i, bus.instr_out, bus.bubble, B2B_OUT[i], B2B_BUB[i]);
      end
      @(negedge clk);
    end
    total++;
    if (bus.done !== 1'b1 || bus.bubble_cnt !== 4'd2) begin
      bad++;
      $display("[TB] FAIL bp_done got done=%b cnt=%0d expected 1 2", bus.done, bus.bubble_cnt);
    end
  endtask

  // Reset lands mid-run; then a lw at the end of one image must not stall the head of the next load.
  task automatic test_reset_mid_run();
    applyStimulus(IMG_B2B);
    repeat (3) @(negedge clk);
    total++;
    if (bus.bubble_cnt !== 4'd2 || bus.instr_out !== 8'h51) begin
      bad++;
      $display("[TB] FAIL mid_before_reset got cnt=%0d out=%h expected 2 51", bus.bubble_cnt, bus.instr_out);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.instr_out, bus.instr_valid, bus.bubble, bus.busy, bus.done, bus.bubble_cnt} !== 16'h0) begin
      bad++;
      $display("[TB] FAIL async_reset got out=%h v=%b b=%b busy=%b done=%b cnt=%0d expected all zero",
               bus.instr_out, bus.instr_valid, bus.bubble, bus.busy, bus.done, bus.bubble_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(IMG_TAIL);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (bus.bubble !== 1'b0 || bus.instr_out !== ((i == 0) ? 8'h51 : ((i == 7) ? 8'hC8 : 8'h00))) begin
        bad++;
        $display("[TB] FAIL restart_slot%0d got out=%h b=%b", i, bus.instr_out, bus.bubble);
      end
      @(negedge clk);
    end
    total++;
    if (bus.done !== 1'b1) begin
      bad++;
      $display("[TB] FAIL restart_done got done=%b expected 1", bus.done);
    end
    bus.instr_bits = IMG_HEAD;
    bus.load       = 1'b1;
    @(negedge clk);
    bus.load       = 1'b0;
    total++;
    if (bus.instr_out !== 8'h51 || bus.bubble !== 1'b0 || bus.busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL load_on_done got out=%h b=%b busy=%b expected 51 0 1", bus.instr_out, bus.bubble, bus.busy);
    end
    repeat (8) @(negedge clk);
    total++;
    if (bus.done !== 1'b1 || bus.bubble_cnt !== 4'd0) begin
      bad++;
      $display("[TB] FAIL head_done got done=%b cnt=%0d expected 1 0", bus.done, bus.bubble_cnt);
    end
  endtask

  task automatic test_load_during_run();
    applyStimulus(IMG_NOHAZ);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        bus.instr_bits = IMG_B2B;
        bus.load       = 1'b1;
      end else begin
        bus.load       = 1'b0;
      end
      total++;
      if (bus.instr_out !== NOHAZ_OUT[i] || bus.bubble !== 1'b0) begin
        bad++;
        $display("[TB] FAIL ldrun_slot%0d got out=%h b=%b expected out=%h b=0",
                 i, bus.instr_out, bus.bubble, NOHAZ_OUT[i]);
      end
      @(negedge clk);
    end
    bus.load = 1'b0;
    total++;
    if (bus.done !== 1'b1 || bus.bubble_cnt !== 4'd0) begin
      bad++;
      $display("[TB] FAIL ldrun_done got done=%b cnt=%0d expected 1 0", bus.done, bus.bubble_cnt);
    end
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || bus.instr_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL ldrun_idle got busy=%b v=%b expected 0 0", bus.busy, bus.instr_valid);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_no_hazard();
    test_back_to_back();
    test_distance2();
    test_backpressure();
    test_reset_mid_run();
    test_load_during_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
